gin_multicast: RTL and testbench
================================

Name: gin_multicast

Overview:
- Global Input Network (GIN): the delivery-side counterpart of the GON opsum collector.
- Accepts one tagged packet per handshake from the buffer/controller side: row_tag, col_tag, value.
- Multicasts the packet to every PE in the XBUS_NUMS x PE_NUMS array whose scan-configured row ID and column ID both equal the tags.
- Drives each PE's {enable, data} input and tracks each PE's ready independently, so every target consumes the packet exactly once.

Parameters:
XBUS_NUMS, 12, number of X-buses (PE rows)
PE_NUMS, 14, PEs per X-bus
ID_LEN, 5, column-ID/col_tag width
ROW_LEN, 4, row-ID/row_tag width
VALUE_LEN, 32, payload width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
enable  input  1  upstream packet valid
ready  output  1  GIN can accept; transfer = enable && ready at a rising edge
row_tag  input  ROW_LEN  destination row tag
col_tag  input  ID_LEN  destination column tag
value  input  VALUE_LEN  payload
set_row  input  1  shift row-ID chain one position
row_scan_in  input  ROW_LEN  row-ID chain input
row_scan_out  output  ROW_LEN  row_id[XBUS_NUMS-1]
set_id  input  1  shift column-ID chain one position
id_scan_in  input  ID_LEN  column-ID chain input
id_scan_out  output  ID_LEN  col_id[XBUS_NUMS*PE_NUMS-1]
pe_ready  input  [XBUS_NUMS*PE_NUMS] x 1  PE k can take data
pe_enable_data  output  [XBUS_NUMS*PE_NUMS] x (VALUE_LEN+1)  PE k: bit VALUE_LEN = enable, low bits = data; k = row*PE_NUMS + col

Behaviour:
- Reset (async, immediate):
  - all row_id and col_id entries go to all-ones;
  - valid_q=0; done mask=0;
  - all pe_enable_data enable bits=0; data bits=0;
  - ready=1; scan outputs = all-ones.
- Disabled entries: an entry whose row_id or col_id is all-ones never matches any tag.
- Row chain, on set_row:
  - row_id[0]<=row_scan_in;
  - row_id[i]<=row_id[i-1].
  - Feeding XBUS_NUMS-1 down to 0 yields row_id[i]=i.
- Column chain, on set_id: same shifting over XBUS_NUMS*PE_NUMS entries. Feeding PE_NUMS-1..0 once per row yields col_id[r*PE_NUMS+c]=c.
- match[k] = valid_q && row_id[k/PE_NUMS]==row_q && col_id[k]==col_q.
- Holding register: on a transfer, capture row_q, col_q and value_q, and set valid_q=1.
- Output is combinational from registers:
  - enable_k = match[k] && !done[k];
  - data_k = value_q when enable_k, else 0.
  - Latency: enables appear in the cycle after the accepting edge.
- Per-PE handshake: at each edge, done[k]<=1 where enable_k && pe_ready[k].
- all_done = AND over k of (!match[k] || done[k] || pe_ready[k]).
- Retire: when valid_q && all_done, clear the done mask.
  - valid_q takes the value of the simultaneous transfer (new packet captured the same edge).
- ready = (!valid_q || all_done) && !set_row && !set_id. This gives one packet per cycle when all targets are ready.
- No-match packet: all_done=1 immediately, so it retires one cycle after acceptance with no enables driven.
- Once done[k]=1, enable_k stays low until the packet retires; no duplicate delivery.
- set_row/set_id shift at any time and block new accepts. An in-flight packet matches against the live IDs; configuration is issued only while idle.
- Both set_row and set_id high in the same cycle: both chains shift.
- Width rules: tags are compared at full width with no truncation; value passes unmodified.

Test Plan:
1. Scan config: after reset, shift rows 11..0, then 12x(13..0).
   - Next 12 set_row pulses with row_scan_in=0 → row_scan_out reads 11,10,…,0.
   - Id chain reads back likewise, 13..0 per row.
2. Unicast, all pe_ready=1:
   - Send (r=3,c=5,value=32'hDEADBEEF) → in the next cycle only pe_enable_data[47]={1,DEADBEEF}.
   - Packet retires that edge; ready stays 1.
   - 168 back-to-back packets covering every (r,c) → one delivery per cycle, each to the matching PE only.
3. Multicast with stagger:
   - Config all row-2 col_ids=0; send (2,0,32'h1234).
   - Raise pe_ready[28+j] at cycle j → each enable drops the cycle after its own handshake; ready=0 until the 14th, then 1.
4. No-match: after reset, send (0,0,x) → no enable ever asserted; packet retires after 1 cycle; ready=1.
5. Reset mid-flight:
   - Assert rst while a multicast is half-delivered → enables drop asynchronously, ready=1, ids all-ones.
   - After release, a new packet still reaches no PE until reconfigured.
6. Config blocking: hold set_id=1 with enable=1 → ready=0, no accept. Drop set_id → accept on the next edge.

Source files
------------

// File: rtl/gin_multicast.sv
// Global Input Network: multicasts one tagged packet to every PE whose
// scan-configured row ID and column ID both equal the packet tags, and
// tracks each PE's handshake so every target consumes it exactly once.
module gin_multicast #(
  parameter int XBUS_NUMS = 12,
  parameter int PE_NUMS   = 14,
  parameter int ID_LEN    = 5,
  parameter int ROW_LEN   = 4,
  parameter int VALUE_LEN = 32
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           enable,
  output logic                                           ready,
  input  logic [ROW_LEN-1:0]                             row_tag,
  input  logic [ID_LEN-1:0]                              col_tag,
  input  logic [VALUE_LEN-1:0]                           value,
  input  logic                                           set_row,
  input  logic [ROW_LEN-1:0]                             row_scan_in,
  output logic [ROW_LEN-1:0]                             row_scan_out,
  input  logic                                           set_id,
  input  logic [ID_LEN-1:0]                              id_scan_in,
  output logic [ID_LEN-1:0]                              id_scan_out,
  input  logic [XBUS_NUMS*PE_NUMS-1:0]                   pe_ready,
  output logic [XBUS_NUMS*PE_NUMS-1:0][VALUE_LEN:0]      pe_enable_data
);

  localparam int N = XBUS_NUMS * PE_NUMS;
  localparam logic [ROW_LEN-1:0] ROW_OFF = '1;
  localparam logic [ID_LEN-1:0]  COL_OFF = '1;

  logic [XBUS_NUMS-1:0][ROW_LEN-1:0] rowId_q, rowId_d;
  logic [N-1:0][ID_LEN-1:0]          colId_q, colId_d;
  logic                              valid_q, valid_d;
  logic [ROW_LEN-1:0]                rowTag_q, rowTag_d;
  logic [ID_LEN-1:0]                 colTag_q, colTag_d;
  logic [VALUE_LEN-1:0]              value_q, value_d;
  logic [N-1:0]                      done_q, done_d;

  logic [N-1:0] match;
  logic [N-1:0] peEn;
  logic         allDone;
  logic         retire;
  logic         accept;

  // An all-ones row or column ID marks the PE as unconfigured, so it can
  // never match even a packet whose tag happens to be all-ones.
  for (genvar k = 0; k < N; k++) begin : gPe
    localparam int R = k / PE_NUMS;
    assign match[k] = valid_q
                      && (rowId_q[R] != ROW_OFF) && (colId_q[k] != COL_OFF)
                      && (rowId_q[R] == rowTag_q) && (colId_q[k] == colTag_q);
    assign peEn[k] = match[k] && !done_q[k];
    assign pe_enable_data[k] = {peEn[k], (peEn[k] ? value_q : {VALUE_LEN{1'b0}})};
  end

  // A packet is finished once every target has either already taken it or
  // is taking it at this edge; configuration shifting blocks new packets.
  assign allDone      = &(~match | done_q | pe_ready);
  assign retire       = valid_q && allDone;
  assign ready        = (!valid_q || allDone) && !set_row && !set_id;
  assign accept       = enable && ready;
  assign row_scan_out = rowId_q[XBUS_NUMS-1];
  assign id_scan_out  = colId_q[N-1];

  // Next state: scan-chain shifts, per-PE delivery mask and holding register.
  always_comb begin
    rowId_d  = rowId_q;
    colId_d  = colId_q;
    valid_d  = valid_q;
    rowTag_d = rowTag_q;
    colTag_d = colTag_q;
    value_d  = value_q;
    done_d   = done_q;
    if (set_row) rowId_d = {rowId_q[XBUS_NUMS-2:0], row_scan_in};
    if (set_id)  colId_d = {colId_q[N-2:0], id_scan_in};
    if (retire) begin
      done_d  = '0;
      valid_d = 1'b0;
    end else begin
      done_d = done_q | (peEn & pe_ready);
    end
    if (accept) begin
      valid_d  = 1'b1;
      rowTag_d = row_tag;
      colTag_d = col_tag;
      value_d  = value;
    end
  end

  // State registers; reset leaves every PE unconfigured and the GIN idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rowId_q  <= '1;
      colId_q  <= '1;
      valid_q  <= 1'b0;
      rowTag_q <= '0;
      colTag_q <= '0;
      value_q  <= '0;
      done_q   <= '0;
    end else begin
      rowId_q  <= rowId_d;
      colId_q  <= colId_d;
      valid_q  <= valid_d;
      rowTag_q <= rowTag_d;
      colTag_q <= colTag_d;
      value_q  <= value_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_gin_multicast.sv
// Self-checking bench for gin_multicast: directed scenarios followed by a
// randomized phase, all compared against a packet-level reference model.
module tb_gin_multicast;

  localparam int XB  = 12;
  localparam int PE  = 14;
  localparam int IDL = 5;
  localparam int RL  = 4;
  localparam int VL  = 32;
  localparam int N   = XB * PE;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  enable;
  logic                  ready;
  logic [RL-1:0]         rowTag;
  logic [IDL-1:0]        colTag;
  logic [VL-1:0]         value;
  logic                  setRow;
  logic [RL-1:0]         rowScanIn;
  logic [RL-1:0]         rowScanOut;
  logic                  setId;
  logic [IDL-1:0]        idScanIn;
  logic [IDL-1:0]        idScanOut;
  logic [N-1:0]          peReady;
  logic [N-1:0][VL:0]    peEnableData;

  int checks = 0;
  int errors = 0;

  // Reference model: configured IDs, the packet being delivered and which
  // PEs have already consumed it.
  int          mRowId[XB];
  int          mColId[N];
  bit          mValid;
  int          mRow;
  int          mCol;
  logic [VL-1:0] mVal;
  bit          mDone[N];

  gin_multicast dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .ready         (ready),
    .row_tag       (rowTag),
    .col_tag       (colTag),
    .value         (value),
    .set_row       (setRow),
    .row_scan_in   (rowScanIn),
    .row_scan_out  (rowScanOut),
    .set_id        (setId),
    .id_scan_in    (idScanIn),
    .id_scan_out   (idScanOut),
    .pe_ready      (peReady),
    .pe_enable_data(peEnableData)
  );

  always #5 clk = ~clk;

  function automatic bit isTarget(int k);
    int r = k / PE;
    return mValid && mRowId[r] != 15 && mColId[k] != 31
           && mRowId[r] == mRow && mColId[k] == mCol;
  endfunction

  function automatic bit expEn(int k);
    return isTarget(k) && !mDone[k];
  endfunction

  function automatic bit allServed();
    for (int k = 0; k < N; k++)
      if (expEn(k) && !peReady[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit expReady();
    return (!mValid || allServed()) && !setRow && !setId;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < XB; i++) mRowId[i] = 15;
    for (int k = 0; k < N; k++) begin
      mColId[k] = 31;
      mDone[k]  = 1'b0;
    end
    mValid = 1'b0;
    mRow   = 0;
    mCol   = 0;
    mVal   = '0;
  endtask

  task automatic modelEdge();
    bit acc;
    bit ret;
    bit served[N];
    acc = enable && expReady();
    ret = mValid && allServed();
    for (int k = 0; k < N; k++) served[k] = expEn(k) && peReady[k];
    for (int k = 0; k < N; k++) mDone[k] = ret ? 1'b0 : (mDone[k] | served[k]);
    if (ret) mValid = 1'b0;
    if (setRow) begin
      for (int i = XB - 1; i > 0; i--) mRowId[i] = mRowId[i-1];
      mRowId[0] = int'(rowScanIn);
    end
    if (setId) begin
      for (int k = N - 1; k > 0; k--) mColId[k] = mColId[k-1];
      mColId[0] = int'(idScanIn);
    end
    if (acc) begin
      mValid = 1'b1;
      mRow   = int'(rowTag);
      mCol   = int'(colTag);
      mVal   = value;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every observable output with the model for the current cycle.
  task automatic checkOutput();
    int firstBad;
    logic [VL:0] want;
    logic [VL:0] badWant;
    chk("ready", {63'd0, ready}, {63'd0, expReady()});
    chk("rowScanOut", 64'(rowScanOut), 64'(mRowId[XB-1]));
    chk("idScanOut", 64'(idScanOut), 64'(mColId[N-1]));
    firstBad = -1;
    badWant  = '0;
    for (int k = 0; k < N; k++) begin
      want = {expEn(k), (expEn(k) ? mVal : {VL{1'b0}})};
      if (peEnableData[k] !== want && firstBad < 0) begin
        firstBad = k;
        badWant  = want;
      end
    end
    checks++;
    assert (firstBad < 0)
    else begin
      errors++;
      $error("[TB] FAIL peEnableData[%0d] observed %0h expected %0h",
             firstBad, peEnableData[firstBad], badWant);
    end
  endtask

  // One clock: check outputs for the inputs just driven, then advance.
  task automatic applyStimulus();
    #1;
    checkOutput();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic loadRows();
    for (int i = XB - 1; i >= 0; i--) begin
      setRow    = 1'b1;
      rowScanIn = RL'(i);
      applyStimulus();
    end
    setRow = 1'b0;
  endtask

  // mode 0: col = k%PE; mode 1: as mode 0 but row 2 all zero; mode 2: random.
  task automatic loadCols(input int mode);
    int v;
    for (int k = N - 1; k >= 0; k--) begin
      if (mode == 0) v = k % PE;
      else if (mode == 1) v = (k / PE == 2) ? 0 : k % PE;
      else begin
        v = int'($urandom_range(0, 16));
        if (v > 13) v = 31;
      end
      setId    = 1'b1;
      idScanIn = IDL'(v);
      applyStimulus();
    end
    setId = 1'b0;
  endtask

  function automatic int enableCount();
    int c = 0;
    for (int k = 0; k < N; k++) c += int'(peEnableData[k][VL]);
    return c;
  endfunction

  initial begin
    rst = 1'b1; enable = 1'b0; rowTag = '0; colTag = '0; value = '0;
    setRow = 1'b0; rowScanIn = '0; setId = 1'b0; idScanIn = '0; peReady = '0;
    modelReset();
    #12;
    checkOutput();
    chk("rstReady", {63'd0, ready}, 64'd1);
    chk("rstEnables", 64'(enableCount()), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] scan configuration");
    loadRows();
    chk("rowCfgOut", 64'(rowScanOut), 64'd11);
    for (int i = 0; i < XB; i++) begin
      chk("rowReadback", 64'(rowScanOut), 64'(11 - i));
      setRow = 1'b1; rowScanIn = '0;
      applyStimulus();
    end
    setRow = 1'b0;
    loadRows();
    loadCols(0);
    chk("colCfgOut", 64'(idScanOut), 64'd13);

    $display("[TB] unicast");
    peReady = '1;
    enable = 1'b1; rowTag = 4'd3; colTag = 5'd5; value = 32'hDEADBEEF;
    applyStimulus();
    chk("unicastPe47", 64'(peEnableData[47]), 64'h1_DEAD_BEEF);
    chk("unicastCount", 64'(enableCount()), 64'd1);
    chk("unicastReady", {63'd0, ready}, 64'd1);
    for (int k = 0; k < N; k++) begin
      rowTag = RL'(k / PE); colTag = IDL'(k % PE); value = $urandom;
      applyStimulus();
    end
    enable = 1'b0;
    applyStimulus();

    $display("[TB] staggered multicast");
    loadCols(1);
    peReady = '0;
    enable = 1'b1; rowTag = 4'd2; colTag = 5'd0; value = 32'h1234;
    applyStimulus();
    enable = 1'b0;
    chk("mcastCount", 64'(enableCount()), 64'd14);
    chk("mcastBlocked", {63'd0, ready}, 64'd0);
    for (int j = 0; j < PE; j++) begin
      peReady[28 + j] = 1'b1;
      applyStimulus();
    end
    chk("mcastDoneReady", {63'd0, ready}, 64'd1);
    chk("mcastDoneCount", 64'(enableCount()), 64'd0);

    $display("[TB] config blocking");
    peReady = '1;
    setId = 1'b1; idScanIn = 5'd4; enable = 1'b1; rowTag = 4'd5; colTag = 5'd3;
    #1;
    chk("cfgBlockReady", {63'd0, ready}, 64'd0);
    applyStimulus();
    applyStimulus();
    setId = 1'b0;
    applyStimulus();
    enable = 1'b0;
    applyStimulus();

    $display("[TB] reset mid-flight");
    loadCols(1);
    peReady = '0;
    enable = 1'b1; rowTag = 4'd2; colTag = 5'd0; value = 32'hCAFE0001;
    applyStimulus();
    enable = 1'b0;
    for (int j = 0; j < 5; j++) begin
      peReady[28 + j] = 1'b1;
      applyStimulus();
    end
    rst = 1'b1;
    modelReset();
    #1;
    chk("midRstEnables", 64'(enableCount()), 64'd0);
    chk("midRstReady", {63'd0, ready}, 64'd1);
    chk("midRstRowScan", 64'(rowScanOut), 64'hF);
    chk("midRstIdScan", 64'(idScanOut), 64'h1F);
    checkOutput();
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] no-match packets");
    peReady = '1;
    enable = 1'b1; rowTag = 4'd0; colTag = 5'd0; value = $urandom;
    applyStimulus();
    enable = 1'b0;
    chk("noMatchReady", {63'd0, ready}, 64'd1);
    chk("noMatchCount", 64'(enableCount()), 64'd0);
    applyStimulus();
    enable = 1'b1; rowTag = 4'd2; colTag = 5'd0;
    applyStimulus();
    enable = 1'b0;
    applyStimulus();

    $display("[TB] randomized traffic");
    loadRows();
    loadCols(2);
    for (int c = 0; c < 400; c++) begin
      enable = 1'($urandom_range(0, 1));
      rowTag = RL'($urandom_range(0, 15));
      colTag = ($urandom_range(0, 3) == 0) ? IDL'($urandom_range(0, 31))
                                           : IDL'($urandom_range(0, 13));
      value  = $urandom;
      for (int k = 0; k < N; k++) peReady[k] = ($urandom_range(0, 3) != 0);
      applyStimulus();
    end
    enable = 1'b0;
    peReady = '1;
    applyStimulus();
    applyStimulus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
